// File: rtl/svd_pkg.sv
// Shared constants for the SVD engine CORDIC datapath.
// Angles are Q3.21 (scale 2^21 = 1.0 rad), matching a 24-bit datapath.
// Contents: PI, PI/2, atan(2^-i) table, CORDIC gain K_15, mode encodings.
package svd_pkg;

  // Fractional bits of the angle/coordinate format these constants are built for.
  localparam int ANGLE_FRAC = 21;

  localparam int PI   = 6588397;  // round(pi   * 2^21)
  localparam int PI_2 = 3294199;  // round(pi/2 * 2^21)

  // round(atan(2^-i) * 2^21), i = 0..15
  localparam int ATAN_TAB [16] = '{
    1647099, 972340, 513757, 260791,
    130902,  65515,  32765,  16384,
    8192,    4096,   2048,   1024,
    512,     256,    128,    64
  };

  // Gain of 15 micro-rotations, prod_{i=0..14} sqrt(1 + 2^-2i).
  localparam real K_15_REAL = 1.6467602571;
  localparam int  K_15      = 3453507;  // round(K_15_REAL * 2^21)

  localparam logic MODE_ROT = 1'b0;  // drive z -> 0
  localparam logic MODE_VEC = 1'b1;  // drive y -> 0

endpackage

// File: rtl/cordic_atan_rom.sv
// Case ROM returning atan(2^-i) in Q3.21 for the current shift index.
// Purely combinational: the angle is valid in the same cycle as shift_bit.
// Ports: shift_bit (iteration index i) -> angle (WIDTH-bit, non-negative).
module cordic_atan_rom
  import svd_pkg::*;
#(
  parameter int WIDTH           = 24,
  parameter int WIDTH_SHIFT_BIT = 4
) (
  input  logic [WIDTH_SHIFT_BIT-1:0] shift_bit,
  output logic [WIDTH-1:0]           angle
);

  always_comb begin
    angle = '0;
    case (shift_bit)
      WIDTH_SHIFT_BIT'(0):  angle = WIDTH'(ATAN_TAB[0]);
      WIDTH_SHIFT_BIT'(1):  angle = WIDTH'(ATAN_TAB[1]);
      WIDTH_SHIFT_BIT'(2):  angle = WIDTH'(ATAN_TAB[2]);
      WIDTH_SHIFT_BIT'(3):  angle = WIDTH'(ATAN_TAB[3]);
      WIDTH_SHIFT_BIT'(4):  angle = WIDTH'(ATAN_TAB[4]);
      WIDTH_SHIFT_BIT'(5):  angle = WIDTH'(ATAN_TAB[5]);
      WIDTH_SHIFT_BIT'(6):  angle = WIDTH'(ATAN_TAB[6]);
      WIDTH_SHIFT_BIT'(7):  angle = WIDTH'(ATAN_TAB[7]);
      WIDTH_SHIFT_BIT'(8):  angle = WIDTH'(ATAN_TAB[8]);
      WIDTH_SHIFT_BIT'(9):  angle = WIDTH'(ATAN_TAB[9]);
      WIDTH_SHIFT_BIT'(10): angle = WIDTH'(ATAN_TAB[10]);
      WIDTH_SHIFT_BIT'(11): angle = WIDTH'(ATAN_TAB[11]);
      WIDTH_SHIFT_BIT'(12): angle = WIDTH'(ATAN_TAB[12]);
      WIDTH_SHIFT_BIT'(13): angle = WIDTH'(ATAN_TAB[13]);
      WIDTH_SHIFT_BIT'(14): angle = WIDTH'(ATAN_TAB[14]);
      WIDTH_SHIFT_BIT'(15): angle = WIDTH'(ATAN_TAB[15]);
      default:              angle = '0;
    endcase
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC: one shift-add micro-rotation per active clock, rotation or
// vectoring mode, unscaled result (gain K_15) with a one-cycle done pulse.
// Latency 16 active cycles from load to done; start=0 freezes every register.
// Ports: clk/rst_n (sync, active-low); start/sel/shift_bit from the control
// counter; mode, x_in/y_in/z_in sampled on load; x/y/z_out registered results;
// busy while iterating; done pulses when the outputs update.
module cordic_iter
  import svd_pkg::*;
#(
  parameter int WIDTH           = 24,
  parameter int WIDTH_SHIFT_BIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sel,
  input  logic [WIDTH_SHIFT_BIT-1:0] shift_bit,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           x_in,
  input  logic [WIDTH-1:0]           y_in,
  input  logic [WIDTH-1:0]           z_in,
  output logic [WIDTH-1:0]           x_out,
  output logic [WIDTH-1:0]           y_out,
  output logic [WIDTH-1:0]           z_out,
  output logic                       busy,
  output logic                       done
);

  // Shift index of the final micro-rotation (frame slot 2^W - 1).
  localparam logic [WIDTH_SHIFT_BIT-1:0] ITER_LAST =
    WIDTH_SHIFT_BIT'((1 << WIDTH_SHIFT_BIT) - 2);
  localparam logic signed [WIDTH-1:0] PI_W = WIDTH'(PI);

  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [WIDTH-1:0]        x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic                    mode_q, mode_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [WIDTH-1:0]        angle;
  logic signed [WIDTH-1:0] x_shr, y_shr, atan_s;
  logic signed [WIDTH-1:0] x_nxt, y_nxt, z_nxt;
  logic                    d_pos;

  cordic_atan_rom #(
    .WIDTH           (WIDTH),
    .WIDTH_SHIFT_BIT (WIDTH_SHIFT_BIT)
  ) u_atan_rom (
    .shift_bit (shift_bit),
    .angle     (angle)
  );

  // Micro-rotation datapath: three add/sub units steered by the direction d.
  always_comb begin
    x_shr  = x_q >>> shift_bit;
    y_shr  = y_q >>> shift_bit;
    atan_s = $signed(angle);
    d_pos  = (mode_q == MODE_ROT) ? !z_q[WIDTH-1] : y_q[WIDTH-1];
    if (d_pos) begin
      x_nxt = x_q - y_shr;
      y_nxt = y_q + x_shr;
      z_nxt = z_q - atan_s;
    end else begin
      x_nxt = x_q + y_shr;
      y_nxt = y_q - x_shr;
      z_nxt = z_q + atan_s;
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (start) begin
      // done only lives until the next active cycle.
      done_d = 1'b0;
      if (!sel) begin
        // Load; a load while busy silently restarts the operation.
        mode_d = mode;
        busy_d = 1'b1;
        if (mode == MODE_VEC && x_in[WIDTH-1]) begin
          // Pre-rotate by pi so the vector starts in the right half-plane,
          // where the micro-rotations converge.
          x_d = -$signed(x_in);
          y_d = -$signed(y_in);
          z_d = y_in[WIDTH-1] ? $signed(z_in) - PI_W : $signed(z_in) + PI_W;
        end else begin
          x_d = $signed(x_in);
          y_d = $signed(y_in);
          z_d = $signed(z_in);
        end
      end else if (busy_q) begin
        x_d = x_nxt;
        y_d = y_nxt;
        z_d = z_nxt;
        if (shift_bit == ITER_LAST) begin
          x_out_d = x_nxt;
          y_out_d = y_nxt;
          z_out_d = z_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/cordic_iter.md
# cordic_iter

Iterative CORDIC micro-rotation datapath for the SVD bidiagonalisation/diagonalisation engine. Sits directly downstream of the iteration `control` counter and consumes its `sel`/`shift_bit` stream. Performs one shift-add micro-rotation per clock in rotation or vectoring mode. Presents the unscaled (gain K ≈ 1.64676) result with a one-cycle `done` pulse.

## Interface
- WIDTH, 24, two's-complement width of x, y, z datapaths
- WIDTH_SHIFT_BIT, 4, width of `shift_bit`; frame length 2^WIDTH_SHIFT_BIT cycles
- ITER_LAST, 2^WIDTH_SHIFT_BIT-2 (14), shift index of the final micro-rotation
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  frame enable; same signal that drives `control.start`, and the datapath freezes while low
- sel  in  1  from control: 0 = load cycle, 1 = iterate cycle
- shift_bit  in  WIDTH_SHIFT_BIT  from control: shift index i of the current iteration
- mode  in  1  0 = rotation (drive z→0), 1 = vectoring (drive y→0); sampled on load
- x_in, y_in, z_in  in  WIDTH each  operands, signed; sampled on load
- x_out, y_out, z_out  out  WIDTH each  registered results
- busy  out  1  iterations in progress
- done  out  1  one-cycle pulse: results updated

## Operation
- Fixed point: x, y, z are signed, scale 2^(WIDTH-3) = 1.0. The z unit is radians, so the range is ±4.
- Hold rule: when start=0, no register changes.
- Load (start=1, sel=0): latch mode.
  - Rotation mode, or vectoring with x_in ≥ 0: x←x_in, y←y_in, z←z_in.
  - Vectoring with x_in < 0 (quadrant pre-rotation): x←−x_in, y←−y_in, z←z_in+PI if y_in ≥ 0, else z_in−PI.
  - x_in = −2^(WIDTH-1) is illegal.
  - On load, busy←1.
- Iterate (start=1, sel=1, busy=1), with i = shift_bit:
  - d = +1 if (rotation and z ≥ 0) or (vectoring and y < 0); otherwise d = −1.
  - x←x − d·(y>>>i), y←y + d·(x>>>i), z←z − d·atan(2^−i).
  - `>>>` is an arithmetic shift. Adds wrap modulo 2^WIDTH with no saturation.
  - Callers keep |x|,|y| < 2^(WIDTH-1)/(2·1.647).
- Final iteration (iterate with i == ITER_LAST): the next-state x/y/z are also written to x_out/y_out/z_out. busy←0 and done←1.
- done is high for exactly one cycle. It clears on the next start=1 cycle; if start=0 it stays high until start returns.
- Iterate cycles with busy=0 (after reset, before the first load) are ignored.
- A load while busy=1 aborts the current operation silently and restarts. No done is produced for the aborted operation.
- Reset: all internal registers, x_out, y_out, z_out, busy and done go to 0.

## Timing
- Frame from control with start held high: count 0,1,…,15 maps to (sel, shift_bit) = (0,15 or 0 after reset), (1,0), …, (1,14).
- Load at frame cycle 0. Iterations i = 0…14 on cycles 1…15, giving 15 micro-rotations.
- done and new outputs are visible in cycle 16, which is the next frame's load cycle. Latency from load to done is 16 active cycles. Throughput is one result per 2^WIDTH_SHIFT_BIT active cycles.
- start low for N cycles stretches the latency by N. Results are bit-identical to the uninterrupted case.
- Outputs remain stable between done pulses.
- atan ROM output is combinational from shift_bit, in the same cycle.

## Structure
- Shared package `svd_pkg`:
  - PI and PI/2 constants at 2^(WIDTH-3) scale.
  - atan(2^−i) table values for i = 0…15, rounded to nearest.
  - The CORDIC gain K_15 constant, for test benches.
  - Mode encoding constants MODE_ROT and MODE_VEC.
- Sub-module `cordic_atan_rom`: input shift_bit, output WIDTH-bit angle. It is a case ROM.
- The remainder is one flat module containing the x/y/z registers, the busy/done flags and three add/sub units.

## Test plan
- **Reset:** rst_n=0 for 3 cycles with start=1, then release → all outputs 0. First done occurs exactly 16 cycles after the first load.
- **Vectoring:** x_in=y_in=2097152 (1.0), z_in=0 → z_out≈1647099 (π/4) and x_out≈4884020, each ±16 LSB; |y_out| ≤ 16.
- **Rotation:** x_in=2097152, y_in=0, z_in=1098066 (π/6) → x_out≈2990840 and y_out≈1726727, each ±16 LSB; |z_out| ≤ 16.
- **Quadrant pre-rotation:** vectoring with x_in=−2097152, y_in=0 → z_out≈6588397 (π), x_out≈3453544, |y_out| ≤ 16.
- **Stall:** deassert start for 5 cycles at iteration 7 → done arrives 5 cycles later. Results are bit-identical to the non-stalled run.
- **Abort and mid-op reset:** a load while busy → no done for the first operation, and correct results for the second. An rst_n pulse mid-operation → outputs are 0 and busy=0 in the next cycle.
